// File: rtl/filter_core_pkg.sv
// Shared types for filter_core_sel: FSM state encoding, soft-start shift table, mode-code helpers.
// The RAMP state and its shift table exist only when FILTER_CORE_SOFT_START_EN is defined.
package filter_core_pkg;

`ifdef FILTER_CORE_SOFT_START_EN
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_RAMP   = 2'd3
    } fc_state_e;

    // Right-shift applied on the 1st..4th strobe of RAMP.
    localparam logic [1:0] RAMP_SHIFT [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
`else
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } fc_state_e;
`endif

    // Mode codes: 0..nch-1 are channels, nch is bypass, nch+1 and above are off.
    function automatic int unsigned mode_bypass(input int unsigned nch);
        return nch;
    endfunction

    function automatic int unsigned mode_off(input int unsigned nch);
        return nch + 1;
    endfunction

endpackage

// File: rtl/fcore_ramp.sv
// Shift-gain stage for the soft-start ramp: arithmetic right shift keeps the sample's sign.
module fcore_ramp #(
    parameter int DW = 12
) (
    input  logic signed [DW-1:0] sample_i,
    input  logic [1:0]           shift_i,
    output logic signed [DW-1:0] sample_o
);
    assign sample_o = sample_i >>> shift_i;
endmodule

// File: rtl/filter_core_sel.sv
// Filter channel selector: picks one of NCH filter outputs, bypass or off, and discards SETTLE strobes
// after a channel switch. Define FILTER_CORE_SOFT_START_EN to add a 4-strobe RAMP before RUN.
module filter_core_sel
    import filter_core_pkg::*;
#(
    parameter int DW     = 12,
    parameter int NCH    = 3,
    parameter int SETTLE = 32,
    parameter int MW     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        f_s,
    input  logic [MW-1:0]               mode_sel,
    input  logic signed [DW-1:0]        din,
    input  logic [NCH*DW-1:0]           fin,
    output logic [NCH-1:0]              en_o,
    output logic signed [DW-1:0]        dout,
    output logic                        dout_vld,
    output logic                        busy,
    output logic [1:0]                  state_o,
    output logic [$clog2(SETTLE+1)-1:0] cnt_o
);
    localparam int              CW         = $clog2(SETTLE + 1);
    localparam logic [MW-1:0]   MODE_BYP   = MW'(mode_bypass(NCH));
    localparam logic [MW:0]     MODE_OFF_X = (MW + 1)'(mode_off(NCH));

    fc_state_e            state_q, state_d;
    logic [MW-1:0]        mode_q;
    logic                 first_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NCH-1:0]       en_q, en_d;
    logic signed [DW-1:0] dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic signed [DW-1:0] src;
    logic                 change, is_off, is_byp;

    // first_q forces the first clock after reset to count as a mode change,
    // since mode_q resets to all ones which may itself be a legal code.
    assign change = first_q || (mode_sel != mode_q);
    assign is_off = {1'b0, mode_sel} >= MODE_OFF_X;
    assign is_byp = (mode_sel == MODE_BYP);

    always_comb begin
        src = din;
        for (int k = 0; k < NCH; k++) begin
            if (mode_q == MW'(k)) src = fin[k*DW +: DW];
        end
    end

`ifdef FILTER_CORE_SOFT_START_EN
    logic signed [DW-1:0] ramp_val;

    fcore_ramp #(.DW(DW)) u_ramp (
        .sample_i (src),
        .shift_i  (RAMP_SHIFT[cnt_q[1:0]]),
        .sample_o (ramp_val)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            mode_q  <= '1;
            first_q <= 1'b1;
            cnt_q   <= '0;
            en_q    <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_sel;
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        if (change) begin
            // A coinciding strobe is swallowed: no count, no output pulse.
            cnt_d  = '0;
            dout_d = '0;
            en_d   = '0;
            if (is_off) begin
                state_d = ST_OFF;
            end else if (is_byp) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_SETTLE;
                for (int k = 0; k < NCH; k++) en_d[k] = (mode_sel == MW'(k));
            end
        end else if (f_s) begin
            vld_d = 1'b1;
            case (state_q)
                ST_SETTLE: begin
                    dout_d = '0;
                    if (cnt_q != CW'(SETTLE)) cnt_d = cnt_q + CW'(1);
                    if (cnt_q >= CW'(SETTLE - 1)) begin
`ifdef FILTER_CORE_SOFT_START_EN
                        state_d = ST_RAMP;
                        cnt_d   = '0;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
`ifdef FILTER_CORE_SOFT_START_EN
                ST_RAMP: begin
                    dout_d = ramp_val;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
`endif
                ST_RUN:  dout_d = src;
                default: dout_d = '0;
            endcase
        end
    end

`ifdef FILTER_CORE_SOFT_START_EN
    assign busy = (state_q == ST_SETTLE) || (state_q == ST_RAMP);
`else
    assign busy = (state_q == ST_SETTLE);
`endif

    assign en_o     = en_q;
    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign state_o  = state_q;
    assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_filter_core_sel.sv
// Self-checking bench for filter_core_sel: settle, channel switch, bypass, coincident change, async reset.
// Expectations follow FILTER_CORE_SOFT_START_EN when the bench is built with it defined.
module tb_filter_core_sel;
    localparam int DW     = 12;
    localparam int NCH    = 3;
    localparam int SETTLE = 32;
    localparam int MW     = 2;
    localparam int CW     = $clog2(SETTLE + 1);
`ifdef FILTER_CORE_SOFT_START_EN
    localparam int RAMP_N = 4;
`else
    localparam int RAMP_N = 0;
`endif
    localparam int A_TOTAL = SETTLE + RAMP_N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 f_s;
    logic [MW-1:0]        mode_sel;
    logic signed [DW-1:0] din;
    logic [NCH*DW-1:0]    fin;
    logic [NCH-1:0]       en_o;
    logic signed [DW-1:0] dout;
    logic                 dout_vld;
    logic                 busy;
    logic [1:0]           state_o;
    logic [CW-1:0]        cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [DW-1:0] exp_q[$];
    logic signed [DW-1:0] mon_exp;

    typedef struct {
        logic [1:0]           mode;
        logic signed [DW-1:0] din;
        logic signed [DW-1:0] fin0;
        logic signed [DW-1:0] fin1;
        logic signed [DW-1:0] fin2;
        logic [2:0]           exp_en;
        logic signed [DW-1:0] exp_dout;
    } vec_t;

    vec_t vec [6];
    int   ramp_a [4] = '{12, 25, 50, 100};

    filter_core_sel #(.DW(DW), .NCH(NCH), .SETTLE(SETTLE), .MW(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_s      (f_s),
        .mode_sel (mode_sel),
        .din      (din),
        .fin      (fin),
        .en_o     (en_o),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .state_o  (state_o),
        .cnt_o    (cnt_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Scoreboard: every dout_vld pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && dout_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vld: got dout %0d with no sample expected", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dout", int'(dout), int'(mon_exp));
            end
        end
    end

    task automatic strobe(input logic signed [DW-1:0] exp_v);
        exp_q.push_back(exp_v);
        @(negedge clk);
        f_s = 1'b1;
        @(negedge clk);
        f_s = 1'b0;
    endtask

    task automatic settle_to(input logic [1:0] m, input logic signed [DW-1:0] v);
        logic [2:0] exp_en;
        exp_en = (int'(m) < NCH) ? 3'(1 << m) : 3'b000;
        @(negedge clk);
        mode_sel = m;
        @(negedge clk);
        check("chg_en", int'(en_o), int'(exp_en));
        check("chg_cnt", int'(cnt_o), 0);
        if (int'(m) < NCH) begin
            check("chg_busy", int'(busy), 1);
            for (int k = 0; k < SETTLE; k++) strobe('0);
            for (int j = 0; j < RAMP_N; j++) strobe(v >>> (3 - j));
        end
    endtask

    initial begin
        logic [1:0] cur_mode;
        int         exp_a;

        vec[0] = '{2'd3, -12'sd500,  12'sd0, 12'sd0,  12'sd0,    3'b000, -12'sd500};
        vec[1] = '{2'd3,  12'sd2047, 12'sd0, 12'sd0,  12'sd0,    3'b000,  12'sd2047};
        vec[2] = '{2'd3, -12'sd2048, 12'sd0, 12'sd0,  12'sd0,    3'b000, -12'sd2048};
        vec[3] = '{2'd2,  12'sd0,    12'sd0, 12'sd0, -12'sd300,  3'b100, -12'sd300};
        vec[4] = '{2'd2,  12'sd77,   12'sd5, 12'sd6, -12'sd301,  3'b100, -12'sd301};
        vec[5] = '{2'd0,  12'sd9,    12'sd1, 12'sd6, -12'sd301,  3'b001,  12'sd1};

        rst      = 1'b1;
        f_s      = 1'b0;
        mode_sel = 2'd0;
        din      = '0;
        fin      = {12'sd300, 12'sd200, 12'sd100};
        repeat (2) @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_en", int'(en_o), 0);
        check("rst_vld", int'(dout_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state_o), 0);
        check("rst_cnt", int'(cnt_o), 0);

        // Channel 0 from reset: 32 discarded strobes, then data (optionally ramped).
        rst = 1'b0;
        @(negedge clk);
        check("a_en", int'(en_o), 1);
        check("a_busy0", int'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            if (k <= SETTLE) exp_a = 0;
            else if (k <= A_TOTAL) exp_a = ramp_a[k - SETTLE - 1];
            else exp_a = 100;
            strobe(DW'(exp_a));
            check("a_busy", int'(busy), (k < A_TOTAL) ? 1 : 0);
        end

        // Restart settle on ch0, then switch to ch1 after 20 strobes.
        @(negedge clk);
        mode_sel = 2'd3;
        @(negedge clk);
        mode_sel = 2'd0;
        @(negedge clk);
        check("sw_en0", int'(en_o), 1);
        for (int k = 0; k < 20; k++) strobe('0);
        check("sw_cnt20", int'(cnt_o), 20);
        settle_to(2'd1, 12'sd200);
        strobe(12'sd200);
        check("sw_en1", int'(en_o), 2);
        cur_mode = 2'd1;

        // Table-driven vectors: bypass values, channel selection, unselected channels ignored.
        for (int i = 0; i < 6; i++) begin
            din = vec[i].din;
            fin = {vec[i].fin2, vec[i].fin1, vec[i].fin0};
            if (vec[i].mode != cur_mode) begin
                settle_to(vec[i].mode, vec[i].exp_dout);
                cur_mode = vec[i].mode;
            end
            check("tbl_en", int'(en_o), int'(vec[i].exp_en));
            strobe(vec[i].exp_dout);
        end

        // Mode change on the same clock as f_s: strobe swallowed, counter stays 0.
        @(negedge clk);
        mode_sel = 2'd1;
        f_s      = 1'b1;
        @(negedge clk);
        f_s = 1'b0;
        check("coin_vld", int'(dout_vld), 0);
        check("coin_cnt", int'(cnt_o), 0);
        check("coin_en", int'(en_o), 2);
        check("coin_busy", int'(busy), 1);
        strobe('0);
        check("coin_cnt1", int'(cnt_o), 1);

        // Switch mid-settle to ch0 carrying 100, then reset asynchronously in RUN.
        fin = {12'sd300, 12'sd200, 12'sd100};
        settle_to(2'd0, 12'sd100);
        strobe(12'sd100);
        check("pre_rst_dout", int'(dout), 100);
        check("pre_rst_en", int'(en_o), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_en", int'(en_o), 0);
        check("arst_vld", int'(dout_vld), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_state", int'(state_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
